uart_cmd_decoder: RTL and testbench
===================================

Name: uart_cmd_decoder

Overview:
- Sits between the UART receive path (`bu_rx_data`/`bu_rx_data_rdy`) and the Lab3 clock core.
- Parses host keystrokes of the form `<cmd><M10><M1><S10><S1>`:
  - `cmd` = `'t'`/`'T'` sets the time.
  - `cmd` = `'a'`/`'A'` sets the alarm.
- Validates each digit and delivers one BCD load strobe plus four held digits to the time/alarm registers.
- Aborts on an invalid character, on ESC (0x1B), or on inactivity timeout.

Parameters:
- TIMEOUT_SECS, 5, number of `oneSecStrb` pulses without a character before a partial command is aborted; 0 disables the timeout.
- TO_W, 3, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_SECS.

Ports:
- clk  in  1  system clock (12 MHz on hardware).
- rst  in  1  synchronous active-high reset.
- oneSecStrb  in  1  one-cycle enable, once per second.
- bu_rx_data  in  8  received ASCII byte.
- bu_rx_data_rdy  in  1  one-cycle strobe; `bu_rx_data` is valid in that cycle.
- ld_time  out  1  one-cycle strobe: load time from the `ld_*` digits.
- ld_alarm  out  1  one-cycle strobe: load alarm from the `ld_*` digits.
- ld_Mtens  out  4  BCD minutes tens (0-5).
- ld_Mones  out  4  BCD minutes ones (0-9).
- ld_Stens  out  4  BCD seconds tens (0-5).
- ld_Sones  out  4  BCD seconds ones (0-9).
- cmd_err  out  1  one-cycle strobe: command aborted (bad char or timeout).
- busy  out  1  high while a command is partially entered.
- dec_tx_data  out  8  echo byte (see Optional Feature).
- dec_tx_data_rdy  out  1  echo strobe.

Behaviour:
- Clock and reset: one clock `clk`; `rst` is synchronous, active-high. Every register changes only on `posedge clk`.
- Reset values:
  - All outputs 0; `ld_*` digits 0.
  - State IDLE; timeout counter 0; `cmd_type` 0.
- States: IDLE, GET_M10, GET_M1, GET_S10, GET_S1.
- `busy` = (state != IDLE).
- IDLE, on `rdy`:
  - `'t'`/`'T'` → `cmd_type`=TIME, go to GET_M10.
  - `'a'`/`'A'` → `cmd_type`=ALARM, go to GET_M10.
  - Any other byte is ignored silently: no `cmd_err`.
- GET_* states, on `rdy`:
  - Valid digit → store `byte - 8'h30` into a shadow digit register, advance to the next state.
  - GET_M10 and GET_S10 accept `'0'..'5'`; GET_M1 and GET_S1 accept `'0'..'9'`.
  - Invalid byte → `cmd_err`=1 for one cycle, go to IDLE, shadow digits discarded.
  - ESC → go to IDLE without `cmd_err` (the global reset generator also fires on ESC).
- Commit on a valid byte in GET_S1:
  - In the next cycle, the `ld_*` outputs take all four shadow digits simultaneously.
  - In that same cycle, exactly one of `ld_time`/`ld_alarm` is 1, selected by `cmd_type`.
  - State returns to IDLE.
  - Latency: last-digit `rdy` cycle + 1.
  - `ld_*` outputs hold until the next commit; partial entries never disturb them.
- Timeout:
  - The counter clears on every `rdy`.
  - In a non-IDLE state it increments on `oneSecStrb`.
  - When it reaches TIMEOUT_SECS: `cmd_err` pulses for one cycle, state goes to IDLE, counter clears.
  - In IDLE the counter is held at 0.
- Simultaneous `rdy` and `oneSecStrb`: the character is processed and the counter clears; no timeout occurs in that cycle.
- A `rdy` in the cycle of a commit or error strobe is processed from IDLE normally; no byte is lost.
- `rst` mid-command: returns to IDLE and clears the outputs, including the held `ld_*` digits, in the next cycle.
- Uppercase and lowercase command letters are equivalent; digits carry no case.

Optional Feature:
- Macro: `UART_CMD_ECHO_EN`.
- When defined:
  - Every byte accepted by the state machine (command letter or valid digit) is echoed: `dec_tx_data` = byte, `dec_tx_data_rdy` = 1 in the cycle after the `rdy`.
  - On commit, the echo byte is 8'h0D.
  - On `cmd_err`, the echo byte is `'?'` (8'h3F), in place of the offending byte.
- When undefined: `dec_tx_data` = 0 and `dec_tx_data_rdy` = 0 constantly, and no echo logic is synthesised.

Decomposition:
- Package `uart_cmd_pkg`:
  - ASCII constants: ASC_0, ASC_5, ASC_9, ASC_ESC, ASC_T_U, ASC_T_L, ASC_A_U, ASC_A_L, ASC_CR, ASC_QM.
  - State encoding localparams.
  - CMD_TIME/CMD_ALARM encoding.
- Sub-module `ascii_bcd_check`:
  - Combinational; inputs are the byte and a `max_is_5` select.
  - Outputs: the 4-bit BCD value and a `valid` flag.
  - Instantiated once and shared across the GET_* states.

Test Plan:
- Reset released; send `'T','1','2','3','4'` → one cycle after the `'4'` `rdy`: `ld_time`=1, Mtens/Mones/Stens/Sones = 1/2/3/4; `ld_alarm`=0; `busy` falls.
- Send `'a','5','9','5','9'` → `ld_alarm`=1 pulse, digits 5/9/5/9; then `'x'` in IDLE → no `cmd_err`, outputs unchanged.
- Send `'t','6'` → `cmd_err` pulse one cycle after `'6'`, state IDLE, `ld_*` still holding the previous 5/9/5/9.
- Send `'A','1'`, then 5 `oneSecStrb` pulses with no `rdy` → `cmd_err` on the 5th strobe, `busy`=0; retest with `rdy` coincident with the 5th strobe → no error.
- Send `'T','1',ESC` → IDLE, no `cmd_err`; assert `rst` during `'A','0','0'` → all outputs 0 the next cycle.
- With `UART_CMD_ECHO_EN` defined: `'T','0','1','0','2'` → echo stream T,0,1,0,2,0x0D; `'T','7'` → echo T,`'?'`.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared constants and encodings for the UART command decoder.
// Echo support is enabled with the UART_CMD_ECHO_EN macro.
package uart_cmd_pkg;

  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_5   = 8'h35;
  localparam logic [7:0] ASC_9   = 8'h39;
  localparam logic [7:0] ASC_ESC = 8'h1B;
  localparam logic [7:0] ASC_T_U = 8'h54;
  localparam logic [7:0] ASC_T_L = 8'h74;
  localparam logic [7:0] ASC_A_U = 8'h41;
  localparam logic [7:0] ASC_A_L = 8'h61;
  localparam logic [7:0] ASC_CR  = 8'h0D;
  localparam logic [7:0] ASC_QM  = 8'h3F;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_GET_M10 = 3'd1;
  localparam logic [2:0] ST_GET_M1  = 3'd2;
  localparam logic [2:0] ST_GET_S10 = 3'd3;
  localparam logic [2:0] ST_GET_S1  = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    GET_M10 = ST_GET_M10,
    GET_M1  = ST_GET_M1,
    GET_S10 = ST_GET_S10,
    GET_S1  = ST_GET_S1
  } state_e;

  localparam logic CMD_TIME_V  = 1'b0;
  localparam logic CMD_ALARM_V = 1'b1;

  typedef enum logic {
    CMD_TIME  = CMD_TIME_V,
    CMD_ALARM = CMD_ALARM_V
  } cmd_e;

endpackage

// File: rtl/ascii_bcd_check.sv
// ASCII digit to BCD converter with range check.
// Upper bound is '5' for tens positions, '9' otherwise.
module ascii_bcd_check
  import uart_cmd_pkg::*;
(
  input  logic [7:0] data_i,
  input  logic       max_is_5_i,
  output logic [3:0] bcd_o,
  output logic       valid_o
);

  logic [7:0] hi;

  assign hi      = max_is_5_i ? ASC_5 : ASC_9;
  assign valid_o = (data_i >= ASC_0) && (data_i <= hi);
  // '0'..'9' are 0x30..0x39, so the low nibble is the digit
  assign bcd_o   = data_i[3:0];

endmodule

// File: rtl/uart_cmd_decoder.sv
// Parses <cmd><M10><M1><S10><S1> keystrokes into BCD load strobes.
// Define UART_CMD_ECHO_EN to echo accepted bytes on dec_tx_data.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_SECS = 5,
  parameter int TO_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oneSecStrb,
  input  logic [7:0] bu_rx_data,
  input  logic       bu_rx_data_rdy,
  output logic       ld_time,
  output logic       ld_alarm,
  output logic [3:0] ld_Mtens,
  output logic [3:0] ld_Mones,
  output logic [3:0] ld_Stens,
  output logic [3:0] ld_Sones,
  output logic       cmd_err,
  output logic       busy,
  output logic [7:0] dec_tx_data,
  output logic       dec_tx_data_rdy
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_SECS - 1);
  localparam logic TO_EN = (TIMEOUT_SECS != 0);

  state_e state_q, state_d;
  cmd_e   type_q, type_d;

  logic [TO_W-1:0] cnt_q, cnt_d;

  logic [3:0] m10_q, m10_d;
  logic [3:0] m1_q, m1_d;
  logic [3:0] s10_q, s10_d;

  logic [3:0] ldm10_q, ldm10_d;
  logic [3:0] ldm1_q, ldm1_d;
  logic [3:0] lds10_q, lds10_d;
  logic [3:0] lds1_q, lds1_d;

  logic ldt_q, ldt_d;
  logic lda_q, lda_d;
  logic err_q, err_d;

  logic       in_cmd;
  logic       is_t, is_a, is_esc;
  logic       max5;
  logic [3:0] bcd;
  logic       dig_ok;
  logic       to_hit;

  assign in_cmd = (state_q != IDLE);
  assign is_t   = (bu_rx_data == ASC_T_U) ||
                  (bu_rx_data == ASC_T_L);
  assign is_a   = (bu_rx_data == ASC_A_U) ||
                  (bu_rx_data == ASC_A_L);
  assign is_esc = (bu_rx_data == ASC_ESC);
  assign max5   = (state_q == GET_M10) ||
                  (state_q == GET_S10);

  // A byte in the same cycle always wins over the timeout
  assign to_hit = TO_EN && in_cmd && oneSecStrb &&
                  !bu_rx_data_rdy && (cnt_q == TO_LAST);

  ascii_bcd_check u_chk (
    .data_i     (bu_rx_data),
    .max_is_5_i (max5),
    .bcd_o      (bcd),
    .valid_o    (dig_ok)
  );

  // Next-state, shadow digits, commit and abort decisions
  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    m10_d   = m10_q;
    m1_d    = m1_q;
    s10_d   = s10_q;
    ldm10_d = ldm10_q;
    ldm1_d  = ldm1_q;
    lds10_d = lds10_q;
    lds1_d  = lds1_q;
    ldt_d   = 1'b0;
    lda_d   = 1'b0;
    err_d   = 1'b0;
    if (bu_rx_data_rdy) begin
      cnt_d = '0;
      if (!in_cmd) begin
        if (is_t) begin
          type_d  = CMD_TIME;
          state_d = GET_M10;
        end else if (is_a) begin
          type_d  = CMD_ALARM;
          state_d = GET_M10;
        end
      end else if (is_esc) begin
        state_d = IDLE;
      end else if (!dig_ok) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          GET_M10: begin
            m10_d   = bcd;
            state_d = GET_M1;
          end
          GET_M1: begin
            m1_d    = bcd;
            state_d = GET_S10;
          end
          GET_S10: begin
            s10_d   = bcd;
            state_d = GET_S1;
          end
          default: begin
            ldm10_d = m10_q;
            ldm1_d  = m1_q;
            lds10_d = s10_q;
            lds1_d  = bcd;
            ldt_d   = (type_q == CMD_TIME);
            lda_d   = (type_q == CMD_ALARM);
            state_d = IDLE;
          end
        endcase
      end
    end else if (to_hit) begin
      err_d   = 1'b1;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!in_cmd) begin
      cnt_d = '0;
    end else if (TO_EN && oneSecStrb) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter, digits and strobe registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= CMD_TIME;
      cnt_q   <= '0;
      m10_q   <= '0;
      m1_q    <= '0;
      s10_q   <= '0;
      ldm10_q <= '0;
      ldm1_q  <= '0;
      lds10_q <= '0;
      lds1_q  <= '0;
      ldt_q   <= 1'b0;
      lda_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
      m10_q   <= m10_d;
      m1_q    <= m1_d;
      s10_q   <= s10_d;
      ldm10_q <= ldm10_d;
      ldm1_q  <= ldm1_d;
      lds10_q <= lds10_d;
      lds1_q  <= lds1_d;
      ldt_q   <= ldt_d;
      lda_q   <= lda_d;
      err_q   <= err_d;
    end
  end

  assign ld_time  = ldt_q;
  assign ld_alarm = lda_q;
  assign cmd_err  = err_q;
  assign busy     = in_cmd;
  assign ld_Mtens = ldm10_q;
  assign ld_Mones = ldm1_q;
  assign ld_Stens = lds10_q;
  assign ld_Sones = lds1_q;

`ifdef UART_CMD_ECHO_EN
  logic [7:0] new_b;
  logic       new_v;
  logic       cr_now;
  logic [7:0] tx_q, tx_d;
  logic       txv_q, txv_d;
  logic [7:0] hold_q, hold_d;
  logic       holdv_q, holdv_d;

  // CR trails the last digit's echo by one cycle
  assign cr_now = ldt_q || lda_q;

  // Echo byte produced by this cycle's input
  always_comb begin
    new_v = 1'b0;
    new_b = '0;
    if (bu_rx_data_rdy) begin
      if (!in_cmd) begin
        new_v = is_t || is_a;
        new_b = bu_rx_data;
      end else if (!is_esc) begin
        new_v = 1'b1;
        new_b = !dig_ok ? ASC_QM : bu_rx_data;
      end
    end else if (to_hit) begin
      new_v = 1'b1;
      new_b = ASC_QM;
    end
  end

  // Output slot: CR first, then a held echo, then new echo
  always_comb begin
    txv_d   = new_v;
    tx_d    = new_b;
    holdv_d = 1'b0;
    hold_d  = '0;
    if (cr_now || holdv_q) begin
      txv_d   = 1'b1;
      tx_d    = cr_now ? ASC_CR : hold_q;
      holdv_d = new_v;
      hold_d  = new_b;
    end
  end

  // Echo registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_q    <= '0;
      txv_q   <= 1'b0;
      hold_q  <= '0;
      holdv_q <= 1'b0;
    end else begin
      tx_q    <= txv_d ? tx_d : 8'h00;
      txv_q   <= txv_d;
      hold_q  <= hold_d;
      holdv_q <= holdv_d;
    end
  end

  assign dec_tx_data     = tx_q;
  assign dec_tx_data_rdy = txv_q;
`else
  assign dec_tx_data     = 8'h00;
  assign dec_tx_data_rdy = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder.
// Echo checks follow the UART_CMD_ECHO_EN macro.
module tb_uart_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       oneSecStrb;
  logic [7:0] bu_rx_data;
  logic       bu_rx_data_rdy;
  logic       ld_time, ld_alarm;
  logic [3:0] ld_Mtens, ld_Mones, ld_Stens, ld_Sones;
  logic       cmd_err, busy;
  logic [7:0] dec_tx_data;
  logic       dec_tx_data_rdy;

  int checks = 0;
  int errors = 0;

  uart_cmd_decoder #(
    .TIMEOUT_SECS (5),
    .TO_W         (3)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .oneSecStrb      (oneSecStrb),
    .bu_rx_data      (bu_rx_data),
    .bu_rx_data_rdy  (bu_rx_data_rdy),
    .ld_time         (ld_time),
    .ld_alarm        (ld_alarm),
    .ld_Mtens        (ld_Mtens),
    .ld_Mones        (ld_Mones),
    .ld_Stens        (ld_Stens),
    .ld_Sones        (ld_Sones),
    .cmd_err         (cmd_err),
    .busy            (busy),
    .dec_tx_data     (dec_tx_data),
    .dec_tx_data_rdy (dec_tx_data_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b,
                      input logic s);
    @(negedge clk);
    bu_rx_data     = b;
    bu_rx_data_rdy = 1'b1;
    oneSecStrb     = s;
    @(negedge clk);
    bu_rx_data     = 8'h00;
    bu_rx_data_rdy = 1'b0;
    oneSecStrb     = 1'b0;
  endtask

  task automatic strobe();
    @(negedge clk);
    oneSecStrb = 1'b1;
    @(negedge clk);
    oneSecStrb = 1'b0;
  endtask

  function automatic logic [15:0] digs();
    return {ld_Mtens, ld_Mones, ld_Stens, ld_Sones};
  endfunction

  initial begin
    rst            = 1'b1;
    oneSecStrb     = 1'b0;
    bu_rx_data     = 8'h00;
    bu_rx_data_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_digits", 32'(digs()), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_strobes",
        32'({ld_time, ld_alarm, cmd_err}), 32'h0);
    chk("rst_tx",
        32'({dec_tx_data_rdy, dec_tx_data}), 32'h0);
    rst = 1'b0;

    send("T", 1'b0);
    chk("T_busy", 32'(busy), 32'h1);
    send("1", 1'b0);
    send("2", 1'b0);
    send("3", 1'b0);
    send("4", 1'b0);
    chk("t1234_ld_time", 32'(ld_time), 32'h1);
    chk("t1234_ld_alarm", 32'(ld_alarm), 32'h0);
    chk("t1234_digits", 32'(digs()), 32'h1234);
    chk("t1234_busy", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t1234_pulse", 32'(ld_time), 32'h0);
    chk("t1234_hold", 32'(digs()), 32'h1234);

    send("a", 1'b0);
    send("5", 1'b0);
    send("9", 1'b0);
    send("5", 1'b0);
    send("9", 1'b0);
    chk("a5959_ld_alarm", 32'(ld_alarm), 32'h1);
    chk("a5959_ld_time", 32'(ld_time), 32'h0);
    chk("a5959_digits", 32'(digs()), 32'h5959);
    send("x", 1'b0);
    chk("x_no_err", 32'(cmd_err), 32'h0);
    chk("x_busy", 32'(busy), 32'h0);
    chk("x_digits", 32'(digs()), 32'h5959);

    send("t", 1'b0);
    send("6", 1'b0);
    chk("t6_err", 32'(cmd_err), 32'h1);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_digits", 32'(digs()), 32'h5959);
    @(negedge clk);
    chk("t6_err_pulse", 32'(cmd_err), 32'h0);

    send("A", 1'b0);
    send("1", 1'b0);
    repeat (4) strobe();
    chk("to4_busy", 32'(busy), 32'h1);
    chk("to4_err", 32'(cmd_err), 32'h0);
    strobe();
    chk("to5_err", 32'(cmd_err), 32'h1);
    chk("to5_busy", 32'(busy), 32'h0);

    send("A", 1'b0);
    send("1", 1'b0);
    repeat (4) strobe();
    send("2", 1'b1);
    chk("coinc_err", 32'(cmd_err), 32'h0);
    chk("coinc_busy", 32'(busy), 32'h1);
    send("3", 1'b0);
    send("4", 1'b0);
    chk("coinc_ld_alarm", 32'(ld_alarm), 32'h1);
    chk("coinc_digits", 32'(digs()), 32'h1234);

    send("T", 1'b0);
    send("1", 1'b0);
    send(8'h1B, 1'b0);
    chk("esc_busy", 32'(busy), 32'h0);
    chk("esc_err", 32'(cmd_err), 32'h0);
    chk("esc_digits", 32'(digs()), 32'h1234);

    send("A", 1'b0);
    send("0", 1'b0);
    send("0", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_digits", 32'(digs()), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;

`ifdef UART_CMD_ECHO_EN
    send("T", 1'b0);
    chk("echo_T", 32'({dec_tx_data_rdy, dec_tx_data}),
        32'h154);
    send("0", 1'b0);
    chk("echo_0a", 32'(dec_tx_data), 32'h30);
    send("1", 1'b0);
    chk("echo_1", 32'(dec_tx_data), 32'h31);
    send("0", 1'b0);
    chk("echo_0b", 32'(dec_tx_data), 32'h30);
    send("2", 1'b0);
    chk("echo_2", 32'({dec_tx_data_rdy, dec_tx_data}),
        32'h132);
    chk("echo_commit", 32'(ld_time), 32'h1);
    @(negedge clk);
    chk("echo_cr", 32'({dec_tx_data_rdy, dec_tx_data}),
        32'h10D);
    send("T", 1'b0);
    chk("echo_T2", 32'(dec_tx_data), 32'h54);
    send("7", 1'b0);
    chk("echo_qm", 32'({dec_tx_data_rdy, dec_tx_data}),
        32'h13F);
    chk("echo_err", 32'(cmd_err), 32'h1);
`else
    send("T", 1'b0);
    chk("noecho_T", 32'({dec_tx_data_rdy, dec_tx_data}),
        32'h0);
    send("7", 1'b0);
    chk("noecho_err", 32'(cmd_err), 32'h1);
    chk("noecho_tx", 32'({dec_tx_data_rdy, dec_tx_data}),
        32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
